// File: rtl/fpu_op_rsl_arb.sv
// fpu_op_rsl_arb: round-robin operand-resolve arbiter between the FPU
// reservation station and the FPU issue stage. Requests whose sources are
// ready in the scoreboard are granted, then held in stage s1 while the FP
// register file is read, and the result is registered in the out stage.
// Optional feature: define FPU_OP_RSL_PERF_EN to add grant/block counters.
module fpu_op_rsl_arb #(
    parameter int PHY_W = 6,
    parameter int DW    = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_flush,
    input  logic                 io_is_op_rsl_0_valid,
    output logic                 io_is_op_rsl_0_ready,
    input  logic [PHY_W-1:0]     io_is_op_rsl_0_bits_rd0,
    input  logic [PHY_W-1:0]     io_is_op_rsl_0_bits_rs1,
    input  logic [PHY_W-1:0]     io_is_op_rsl_0_bits_rs2,
    input  logic [PHY_W-1:0]     io_is_op_rsl_0_bits_rs3,
    input  logic                 io_is_op_rsl_1_valid,
    output logic                 io_is_op_rsl_1_ready,
    input  logic [PHY_W-1:0]     io_is_op_rsl_1_bits_rd0,
    input  logic [PHY_W-1:0]     io_is_op_rsl_1_bits_rs1,
    input  logic [PHY_W-1:0]     io_is_op_rsl_1_bits_rs2,
    input  logic [PHY_W-1:0]     io_is_op_rsl_1_bits_rs3,
    input  logic                 io_is_op_rsl_2_valid,
    output logic                 io_is_op_rsl_2_ready,
    input  logic [PHY_W-1:0]     io_is_op_rsl_2_bits_rd0,
    input  logic [PHY_W-1:0]     io_is_op_rsl_2_bits_rs1,
    input  logic [PHY_W-1:0]     io_is_op_rsl_2_bits_rs2,
    input  logic [PHY_W-1:0]     io_is_op_rsl_2_bits_rs3,
    input  logic                 io_is_op_rsl_3_valid,
    output logic                 io_is_op_rsl_3_ready,
    input  logic [PHY_W-1:0]     io_is_op_rsl_3_bits_rd0,
    input  logic [PHY_W-1:0]     io_is_op_rsl_3_bits_rs1,
    input  logic [PHY_W-1:0]     io_is_op_rsl_3_bits_rs2,
    input  logic [PHY_W-1:0]     io_is_op_rsl_3_bits_rs3,
    input  logic [2**PHY_W-1:0]  io_phy_ready,
    output logic [PHY_W-1:0]     io_rf_raddr_1,
    output logic [PHY_W-1:0]     io_rf_raddr_2,
    output logic [PHY_W-1:0]     io_rf_raddr_3,
    input  logic [DW-1:0]        io_rf_rdata_1,
    input  logic [DW-1:0]        io_rf_rdata_2,
    input  logic [DW-1:0]        io_rf_rdata_3,
    output logic                 io_rsl_out_valid,
    input  logic                 io_rsl_out_ready,
    output logic [PHY_W-1:0]     io_rsl_out_bits_rd0,
    output logic [DW-1:0]        io_rsl_out_bits_op1,
    output logic [DW-1:0]        io_rsl_out_bits_op2,
    output logic [DW-1:0]        io_rsl_out_bits_op3,
    output logic [1:0]           io_rsl_out_bits_port
`ifdef FPU_OP_RSL_PERF_EN
    ,
    output logic [31:0]          io_perf_grant_cnt,
    output logic [31:0]          io_perf_block_cnt
`endif
);

    logic [3:0]       req_valid;
    logic [PHY_W-1:0] req_rd0 [4];
    logic [PHY_W-1:0] req_rs1 [4];
    logic [PHY_W-1:0] req_rs2 [4];
    logic [PHY_W-1:0] req_rs3 [4];

    assign req_valid = {io_is_op_rsl_3_valid, io_is_op_rsl_2_valid,
                        io_is_op_rsl_1_valid, io_is_op_rsl_0_valid};
    assign req_rd0[0] = io_is_op_rsl_0_bits_rd0;
    assign req_rd0[1] = io_is_op_rsl_1_bits_rd0;
    assign req_rd0[2] = io_is_op_rsl_2_bits_rd0;
    assign req_rd0[3] = io_is_op_rsl_3_bits_rd0;
    assign req_rs1[0] = io_is_op_rsl_0_bits_rs1;
    assign req_rs1[1] = io_is_op_rsl_1_bits_rs1;
    assign req_rs1[2] = io_is_op_rsl_2_bits_rs1;
    assign req_rs1[3] = io_is_op_rsl_3_bits_rs1;
    assign req_rs2[0] = io_is_op_rsl_0_bits_rs2;
    assign req_rs2[1] = io_is_op_rsl_1_bits_rs2;
    assign req_rs2[2] = io_is_op_rsl_2_bits_rs2;
    assign req_rs2[3] = io_is_op_rsl_3_bits_rs2;
    assign req_rs3[0] = io_is_op_rsl_0_bits_rs3;
    assign req_rs3[1] = io_is_op_rsl_1_bits_rs3;
    assign req_rs3[2] = io_is_op_rsl_2_bits_rs3;
    assign req_rs3[3] = io_is_op_rsl_3_bits_rs3;

    logic             s1_valid_q, s1_valid_d;
    logic [PHY_W-1:0] s1_rd0_q, s1_rd0_d, s1_rs1_q, s1_rs1_d;
    logic [PHY_W-1:0] s1_rs2_q, s1_rs2_d, s1_rs3_q, s1_rs3_d;
    logic [1:0]       s1_port_q, s1_port_d;
    logic             out_valid_q, out_valid_d;
    logic [PHY_W-1:0] out_rd0_q, out_rd0_d;
    logic [DW-1:0]    out_op1_q, out_op1_d, out_op2_q, out_op2_d, out_op3_q, out_op3_d;
    logic [1:0]       out_port_q, out_port_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;

    logic       out_fire, s1_adv, accept, grant;
    logic [1:0] grant_port, idx;
    logic [3:0] elig, grant_vec;

    // Eligibility, pipeline advance and round-robin grant search.
    always_comb begin
        elig       = '0;
        grant      = 1'b0;
        grant_port = rr_ptr_q;
        idx        = rr_ptr_q;
        grant_vec  = '0;
        out_fire   = out_valid_q & io_rsl_out_ready;
        s1_adv     = s1_valid_q & (~out_valid_q | out_fire);
        accept     = ~io_flush & (~s1_valid_q | s1_adv);
        for (int n = 0; n < 4; n++) begin
            elig[n] = req_valid[n] & io_phy_ready[req_rs1[n]]
                    & io_phy_ready[req_rs2[n]] & io_phy_ready[req_rs3[n]];
        end
        if (accept) begin
            for (int i = 0; i < 4; i++) begin
                idx = rr_ptr_q + 2'(i);
                if (!grant && elig[idx]) begin
                    grant      = 1'b1;
                    grant_port = idx;
                end
            end
        end
        if (grant) grant_vec = 4'(1) << grant_port;
    end

    // Ready is dropped while reset is asserted so it falls immediately, not at an edge.
    assign {io_is_op_rsl_3_ready, io_is_op_rsl_2_ready,
            io_is_op_rsl_1_ready, io_is_op_rsl_0_ready} = grant_vec & {4{reset}};

    // Next-state for the s1 and out stages and the round-robin pointer.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_rd0_d    = s1_rd0_q;
        s1_rs1_d    = s1_rs1_q;
        s1_rs2_d    = s1_rs2_q;
        s1_rs3_d    = s1_rs3_q;
        s1_port_d   = s1_port_q;
        out_valid_d = out_valid_q;
        out_rd0_d   = out_rd0_q;
        out_op1_d   = out_op1_q;
        out_op2_d   = out_op2_q;
        out_op3_d   = out_op3_q;
        out_port_d  = out_port_q;
        rr_ptr_d    = rr_ptr_q;
        if (io_flush) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            if (s1_adv) begin
                out_valid_d = 1'b1;
                out_rd0_d   = s1_rd0_q;
                out_port_d  = s1_port_q;
                out_op1_d   = io_rf_rdata_1;
                out_op2_d   = io_rf_rdata_2;
                out_op3_d   = io_rf_rdata_3;
                s1_valid_d  = 1'b0;
            end else if (out_fire) begin
                out_valid_d = 1'b0;
            end
            if (grant) begin
                s1_valid_d = 1'b1;
                s1_rd0_d   = req_rd0[grant_port];
                s1_rs1_d   = req_rs1[grant_port];
                s1_rs2_d   = req_rs2[grant_port];
                s1_rs3_d   = req_rs3[grant_port];
                s1_port_d  = grant_port;
                rr_ptr_d   = grant_port + 2'd1;
            end
        end
    end

    // Pipeline and pointer registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s1_rd0_q    <= '0;
            s1_rs1_q    <= '0;
            s1_rs2_q    <= '0;
            s1_rs3_q    <= '0;
            s1_port_q   <= '0;
            out_valid_q <= 1'b0;
            out_rd0_q   <= '0;
            out_op1_q   <= '0;
            out_op2_q   <= '0;
            out_op3_q   <= '0;
            out_port_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_rd0_q    <= s1_rd0_d;
            s1_rs1_q    <= s1_rs1_d;
            s1_rs2_q    <= s1_rs2_d;
            s1_rs3_q    <= s1_rs3_d;
            s1_port_q   <= s1_port_d;
            out_valid_q <= out_valid_d;
            out_rd0_q   <= out_rd0_d;
            out_op1_q   <= out_op1_d;
            out_op2_q   <= out_op2_d;
            out_op3_q   <= out_op3_d;
            out_port_q  <= out_port_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign io_rf_raddr_1        = s1_rs1_q;
    assign io_rf_raddr_2        = s1_rs2_q;
    assign io_rf_raddr_3        = s1_rs3_q;
    assign io_rsl_out_valid     = out_valid_q;
    assign io_rsl_out_bits_rd0  = out_rd0_q;
    assign io_rsl_out_bits_op1  = out_op1_q;
    assign io_rsl_out_bits_op2  = out_op2_q;
    assign io_rsl_out_bits_op3  = out_op3_q;
    assign io_rsl_out_bits_port = out_port_q;

`ifdef FPU_OP_RSL_PERF_EN
    logic [31:0] perf_grant_cnt_q, perf_grant_cnt_d;
    logic [31:0] perf_block_cnt_q, perf_block_cnt_d;

    // Counters wrap naturally and are deliberately untouched by flush.
    always_comb begin
        perf_grant_cnt_d = perf_grant_cnt_q;
        perf_block_cnt_d = perf_block_cnt_q;
        if (grant) perf_grant_cnt_d = perf_grant_cnt_q + 32'd1;
        else if (|req_valid) perf_block_cnt_d = perf_block_cnt_q + 32'd1;
    end

    // Performance counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_grant_cnt_q <= '0;
            perf_block_cnt_q <= '0;
        end else begin
            perf_grant_cnt_q <= perf_grant_cnt_d;
            perf_block_cnt_q <= perf_block_cnt_d;
        end
    end

    assign io_perf_grant_cnt = perf_grant_cnt_q;
    assign io_perf_block_cnt = perf_block_cnt_q;
`endif

endmodule

// File: tb/tb_fpu_op_rsl_arb.sv
// Directed testbench for fpu_op_rsl_arb. Define FPU_OP_RSL_PERF_EN to also
// exercise the performance counters.
module tb_fpu_op_rsl_arb;

    localparam int PHY_W = 6;
    localparam int DW    = 64;

    logic                clock, reset, io_flush, out_ready;
    logic [3:0]          v;
    wire  [3:0]          rdy;
    logic [PHY_W-1:0]    rd0 [4];
    logic [PHY_W-1:0]    rs1 [4];
    logic [PHY_W-1:0]    rs2 [4];
    logic [PHY_W-1:0]    rs3 [4];
    logic [2**PHY_W-1:0] phy_ready;
    wire  [PHY_W-1:0]    raddr1, raddr2, raddr3;
    logic [DW-1:0]       rdata1, rdata2, rdata3;
    wire                 out_valid;
    wire  [PHY_W-1:0]    out_rd0;
    wire  [DW-1:0]       op1, op2, op3;
    wire  [1:0]          out_port;
`ifdef FPU_OP_RSL_PERF_EN
    wire  [31:0]         grant_cnt, block_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    fpu_op_rsl_arb #(.PHY_W(PHY_W), .DW(DW)) dut (
        .clock(clock), .reset(reset), .io_flush(io_flush),
        .io_is_op_rsl_0_valid(v[0]), .io_is_op_rsl_0_ready(rdy[0]),
        .io_is_op_rsl_0_bits_rd0(rd0[0]), .io_is_op_rsl_0_bits_rs1(rs1[0]),
        .io_is_op_rsl_0_bits_rs2(rs2[0]), .io_is_op_rsl_0_bits_rs3(rs3[0]),
        .io_is_op_rsl_1_valid(v[1]), .io_is_op_rsl_1_ready(rdy[1]),
        .io_is_op_rsl_1_bits_rd0(rd0[1]), .io_is_op_rsl_1_bits_rs1(rs1[1]),
        .io_is_op_rsl_1_bits_rs2(rs2[1]), .io_is_op_rsl_1_bits_rs3(rs3[1]),
        .io_is_op_rsl_2_valid(v[2]), .io_is_op_rsl_2_ready(rdy[2]),
        .io_is_op_rsl_2_bits_rd0(rd0[2]), .io_is_op_rsl_2_bits_rs1(rs1[2]),
        .io_is_op_rsl_2_bits_rs2(rs2[2]), .io_is_op_rsl_2_bits_rs3(rs3[2]),
        .io_is_op_rsl_3_valid(v[3]), .io_is_op_rsl_3_ready(rdy[3]),
        .io_is_op_rsl_3_bits_rd0(rd0[3]), .io_is_op_rsl_3_bits_rs1(rs1[3]),
        .io_is_op_rsl_3_bits_rs2(rs2[3]), .io_is_op_rsl_3_bits_rs3(rs3[3]),
        .io_phy_ready(phy_ready),
        .io_rf_raddr_1(raddr1), .io_rf_raddr_2(raddr2), .io_rf_raddr_3(raddr3),
        .io_rf_rdata_1(rdata1), .io_rf_rdata_2(rdata2), .io_rf_rdata_3(rdata3),
        .io_rsl_out_valid(out_valid), .io_rsl_out_ready(out_ready),
        .io_rsl_out_bits_rd0(out_rd0), .io_rsl_out_bits_op1(op1),
        .io_rsl_out_bits_op2(op2), .io_rsl_out_bits_op3(op3),
        .io_rsl_out_bits_port(out_port)
`ifdef FPU_OP_RSL_PERF_EN
        , .io_perf_grant_cnt(grant_cnt), .io_perf_block_cnt(block_cnt)
`endif
    );

    // Register-file model: the value encodes read port and address.
    function automatic logic [DW-1:0] rf(input int k, input logic [PHY_W-1:0] a);
        return 64'hA5A5_0000_0000_0000 | (64'(k) << 32) | (64'(a) << 4) | 64'(k);
    endfunction

    always_comb begin
        rdata1 = rf(1, raddr1);
        rdata2 = rf(2, raddr2);
        rdata3 = rf(3, raddr3);
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_defaults();
        for (int n = 0; n < 4; n++) begin
            rd0[n] = PHY_W'(40 + n);
            rs1[n] = PHY_W'(4 * n + 1);
            rs2[n] = PHY_W'(4 * n + 2);
            rs3[n] = PHY_W'(4 * n + 3);
        end
    endtask

    task automatic chk_out(input string tag, input int p);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_port"}, 64'(out_port), 64'(p));
        chk({tag, "_rd0"}, 64'(out_rd0), 64'(40 + p));
        chk({tag, "_op1"}, op1, rf(1, PHY_W'(4 * p + 1)));
        chk({tag, "_op2"}, op2, rf(2, PHY_W'(4 * p + 2)));
        chk({tag, "_op3"}, op3, rf(3, PHY_W'(4 * p + 3)));
    endtask

    initial begin
        reset = 1'b0; io_flush = 1'b0; out_ready = 1'b1;
        v = 4'b1111; phy_ready = '1;
        set_defaults();

        // Reset state with all requests valid and eligible.
        #11;
        chk("rst_ready", 64'(rdy), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_raddr1", 64'(raddr1), 64'd0);
        chk("rst_out_rd0", 64'(out_rd0), 64'd0);
        reset = 1'b1;
        #1;
        chk("rr_first_ready", 64'(rdy), 64'b0001);

        // Round robin 0,1,2,3,0 with 1/cycle throughput after 2-cycle latency.
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("rr_ready", 64'(rdy), 64'(4'(1) << (k % 4)));
            if (k == 1) begin
                chk("rr_lat_out_valid", 64'(out_valid), 64'd0);
                chk("rr_s1_raddr1", 64'(raddr1), 64'd1);
            end else begin
                chk_out("rr_out", k - 2);
            end
        end
        v = 4'b0000;
        #1;
        chk("idle_ready", 64'(rdy), 64'd0);
        step();
        chk_out("drain_out", 0);
        step();
        chk("drain_empty", 64'(out_valid), 64'd0);

        // Port 1 blocked on rs2=5 for three cycles.
        rs1[1] = 6'd20; rs2[1] = 6'd5; rs3[1] = 6'd21;
        phy_ready[5] = 1'b0;
        v = 4'b0010;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("sb_blocked_ready", 64'(rdy), 64'd0);
            step();
        end
        phy_ready[5] = 1'b1;
        #1;
        chk("sb_ready", 64'(rdy), 64'b0010);
        step();
        chk("sb_raddr2", 64'(raddr2), 64'd5);
        v = 4'b0000;
        phy_ready[5] = 1'b0;
        step();
        chk("sb_out_valid", 64'(out_valid), 64'd1);
        chk("sb_out_port", 64'(out_port), 64'd1);
        chk("sb_out_rd0", 64'(out_rd0), 64'd41);
        chk("sb_out_op1", op1, rf(1, 6'd20));
        chk("sb_out_op2", op2, rf(2, 6'd5));
        step();
        chk("sb_empty", 64'(out_valid), 64'd0);
        phy_ready = '1;
        set_defaults();

        // Stall with ports 0 and 2 valid; rr pointer is now 2.
        out_ready = 1'b0;
        v = 4'b0101;
        #1;
        chk("stall_ready_a", 64'(rdy), 64'b0100);
        step();
        chk("stall_ready_b", 64'(rdy), 64'b0001);
        step();
        chk("stall_ready_full", 64'(rdy), 64'd0);
        chk_out("stall_out_a", 2);
        step();
        chk("stall_ready_hold", 64'(rdy), 64'd0);
        chk_out("stall_out_hold", 2);
        out_ready = 1'b1;
        v = 4'b0000;
        step();
        chk_out("stall_release", 0);
        step();
        chk("stall_empty", 64'(out_valid), 64'd0);

        // Flush with both stages full; rr pointer is now 1.
        out_ready = 1'b0;
        v = 4'b1010;
        #1;
        chk("fl_ready_a", 64'(rdy), 64'b0010);
        step();
        chk("fl_ready_b", 64'(rdy), 64'b1000);
        step();
        chk_out("fl_out_full", 1);
        out_ready = 1'b1;
        io_flush  = 1'b1;
        #1;
        chk("fl_no_ready", 64'(rdy), 64'd0);
        step();
        chk("fl_out_cleared", 64'(out_valid), 64'd0);
        io_flush = 1'b0;
        v = 4'b0000;
        step();
        chk("fl_s1_cleared", 64'(out_valid), 64'd0);
        v = 4'b1010;
        #1;
        chk("fl_rr_kept", 64'(rdy), 64'b0010);

        // Asynchronous reset mid-stream.
        step();
        step();
        chk_out("ar_out_before", 1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_out_valid", 64'(out_valid), 64'd0);
        chk("ar_ready", 64'(rdy), 64'd0);
        chk("ar_raddr1", 64'(raddr1), 64'd0);
        v = 4'b1111;
        #1;
        reset = 1'b1;
        #1;
        chk("ar_first_ready", 64'(rdy), 64'b0001);
        step();
        step();
        chk_out("ar_out_after", 0);

`ifdef FPU_OP_RSL_PERF_EN
        // Ten grants then four blocked cycles from a fresh reset.
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("perf_rst_grant", 64'(grant_cnt), 64'd0);
        chk("perf_rst_block", 64'(block_cnt), 64'd0);
        reset = 1'b1;
        out_ready = 1'b1;
        v = 4'b1111;
        for (int k = 0; k < 10; k++) step();
        chk("perf_grant_10", 64'(grant_cnt), 64'd10);
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) step();
        v = 4'b0000;
        chk("perf_grant_hold", 64'(grant_cnt), 64'd10);
        chk("perf_block_4", 64'(block_cnt), 64'd4);
        step();
        chk("perf_idle_block", 64'(block_cnt), 64'd4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
